// File: rtl/lives_controller_pkg.sv
// Shared types and defaults for the ship lives controller and its counter interface.
package lives_controller_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    SETTLE,
    PLAY,
    HIT,
    CHECK,
    INVULN,
    BONUS,
    SETTLE_B,
    GAME_OVER
  } state_t;

  localparam int unsigned INIT_LIVES_DEF = 3;
  localparam int unsigned MAX_LIVES_DEF  = 9;

  typedef logic [3:0] lives_d_t;

  function automatic lives_d_t lives_inc(lives_d_t q);
    return q + lives_d_t'(1);
  endfunction

endpackage

// File: rtl/lives_controller_if.sv
// Command/status bundle between the lives controller and the 16-bit lives counter.
interface lives_controller_if;
  import lives_controller_pkg::*;

  logic        cnt_clr;
  logic        cnt_ld;
  logic        cnt_ent;
  logic        cnt_enp;
  lives_d_t    cnt_d;
  logic [15:0] lives_q;
  logic        lives_zero;

  modport master (
    output cnt_clr, cnt_ld, cnt_ent, cnt_enp, cnt_d,
    input  lives_q, lives_zero
  );

  modport slave (
    input  cnt_clr, cnt_ld, cnt_ent, cnt_enp, cnt_d,
    output lives_q, lives_zero
  );
endinterface

// File: rtl/lives_controller_invuln_timer.sv
// Invulnerability frame counter: loaded after a hit, counts frame ticks down while running.
module lives_controller_invuln_timer #(
  parameter int unsigned TICK_W       = 8,
  parameter int unsigned INVULN_TICKS = 60
) (
  input  logic clock,
  input  logic clr_n,
  input  logic load,
  input  logic run,
  input  logic frame_tick,
  output logic expire
);

  logic [TICK_W-1:0] count;

  always_ff @(posedge clock) begin
    if (!clr_n) begin
      count <= '0;
    end else if (load) begin
      count <= TICK_W'(INVULN_TICKS);
    end else if (run && frame_tick && (count != '0)) begin
      count <= count - TICK_W'(1);
    end
  end

  // Expiry is flagged on the final tick itself so the window spans exactly INVULN_TICKS ticks.
  assign expire = run && ((count == '0) || (frame_tick && (count == TICK_W'(1))));

endmodule

// File: rtl/lives_controller.sv
// Player lives sequencer: drives the lives counter on game start, hits and bonuses,
// with a post-hit invulnerability window and game-over detection.
module lives_controller
  import lives_controller_pkg::*;
#(
  parameter int unsigned INIT_LIVES   = INIT_LIVES_DEF,
  parameter int unsigned MAX_LIVES    = MAX_LIVES_DEF,
  parameter int unsigned INVULN_TICKS = 60,
  parameter int unsigned TICK_W       = 8
) (
  input  logic                  clock,
  input  logic                  clr_n,
  input  logic                  start,
  input  logic                  collision,
  input  logic                  bonus,
  input  logic                  frame_tick,
  lives_controller_if.master    ctr,
  output logic                  playing,
  output logic                  invulnerable,
  output logic                  life_lost,
  output logic                  game_over
);

  state_t   state, state_next;
  logic     ret_inv, ret_inv_next;
  logic     timer_load, timer_expire;
  logic     below_max, q_zero;

  logic     ld_next, dec_next, playing_next, invuln_next, lost_next, over_next;
  lives_d_t d_next;

  assign below_max = ctr.lives_q < 16'(MAX_LIVES);
  assign q_zero    = (ctr.lives_q == '0);

  lives_controller_invuln_timer #(
    .TICK_W       (TICK_W),
    .INVULN_TICKS (INVULN_TICKS)
  ) u_timer (
    .clock      (clock),
    .clr_n      (clr_n),
    .load       (timer_load),
    .run        (state == INVULN),
    .frame_tick (frame_tick),
    .expire     (timer_expire)
  );

  always_comb begin
    state_next   = state;
    ret_inv_next = ret_inv;
    timer_load   = 1'b0;
    unique case (state)
      IDLE:      if (start) state_next = LOAD;
      LOAD:      state_next = SETTLE;
      SETTLE:    state_next = PLAY;
      PLAY: begin
        if (collision) begin
          state_next = q_zero ? GAME_OVER : HIT;
        end else if (bonus && below_max) begin
          state_next   = BONUS;
          ret_inv_next = 1'b0;
        end
      end
      HIT:       state_next = CHECK;
      CHECK: begin
        if (q_zero || ctr.lives_zero) begin
          state_next = GAME_OVER;
        end else begin
          state_next = INVULN;
          timer_load = 1'b1;
        end
      end
      INVULN: begin
        if (timer_expire) begin
          state_next = PLAY;
        end else if (bonus && below_max) begin
          state_next   = BONUS;
          ret_inv_next = 1'b1;
        end
      end
      BONUS:     state_next = SETTLE_B;
      SETTLE_B:  state_next = ret_inv ? INVULN : PLAY;
      GAME_OVER: if (start) state_next = LOAD;
      default:   state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they track the state register.
  always_comb begin
    ld_next      = (state_next == LOAD) || (state_next == BONUS);
    dec_next     = (state_next == HIT);
    playing_next = (state_next == PLAY) || (state_next == INVULN);
    invuln_next  = (state_next == INVULN);
    lost_next    = (state_next == HIT);
    over_next    = (state_next == GAME_OVER);
    d_next       = '0;
    if (state_next == LOAD) begin
      d_next = lives_d_t'(INIT_LIVES);
    end else if (state_next == BONUS) begin
      d_next = lives_inc(ctr.lives_q[3:0]);
    end
  end

  always_ff @(posedge clock) begin
    if (!clr_n) begin
      state        <= IDLE;
      ret_inv      <= 1'b0;
      ctr.cnt_clr  <= 1'b1;
      ctr.cnt_ld   <= 1'b0;
      ctr.cnt_ent  <= 1'b0;
      ctr.cnt_enp  <= 1'b0;
      ctr.cnt_d    <= '0;
      playing      <= 1'b0;
      invulnerable <= 1'b0;
      life_lost    <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state        <= state_next;
      ret_inv      <= ret_inv_next;
      ctr.cnt_clr  <= 1'b0;
      ctr.cnt_ld   <= ld_next;
      ctr.cnt_ent  <= dec_next;
      ctr.cnt_enp  <= dec_next;
      ctr.cnt_d    <= d_next;
      playing      <= playing_next;
      invulnerable <= invuln_next;
      life_lost    <= lost_next;
      game_over    <= over_next;
    end
  end

endmodule

// File: tb/tb_lives_controller.sv
// Directed bench for lives_controller with a behavioural 16-bit down-counter on the counter side.
module tb_lives_controller;

  logic clock = 1'b0;
  logic clr_n, start, collision, bonus, frame_tick;
  logic playing, invulnerable, life_lost, game_over;

  int checks = 0;
  int errors = 0;
  int n;
  logic saw_dec;

  lives_controller_if bus ();

  lives_controller #(
    .INIT_LIVES   (3),
    .MAX_LIVES    (9),
    .INVULN_TICKS (60),
    .TICK_W       (8)
  ) dut (
    .clock        (clock),
    .clr_n        (clr_n),
    .start        (start),
    .collision    (collision),
    .bonus        (bonus),
    .frame_tick   (frame_tick),
    .ctr          (bus),
    .playing      (playing),
    .invulnerable (invulnerable),
    .life_lost    (life_lost),
    .game_over    (game_over)
  );

  always #5 clock = ~clock;

  // Counter model: sync clear, sync load, count down when both enables are high.
  always @(posedge clock) begin
    if (bus.cnt_clr === 1'b1)                              bus.lives_q <= '0;
    else if (bus.cnt_ld === 1'b1)                          bus.lives_q <= {12'b0, bus.cnt_d};
    else if (bus.cnt_ent === 1'b1 && bus.cnt_enp === 1'b1) bus.lives_q <= bus.lives_q - 16'd1;
  end
  assign bus.lives_zero = bus.cnt_ent && bus.cnt_enp && (bus.lives_q == 16'd0);

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_invuln(output int cnt);
    frame_tick = 1'b1;
    cnt = 0;
    while (invulnerable && cnt < 200) begin
      step();
      cnt++;
    end
    frame_tick = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clr_n = 1'b0; start = 1'b0; collision = 1'b0; bonus = 1'b0; frame_tick = 1'b0;

    step();
    check("rst_clr", bus.cnt_clr, 1);
    check("rst_ld", bus.cnt_ld, 0);
    check("rst_ent", bus.cnt_ent, 0);
    check("rst_d", bus.cnt_d, 0);
    check("rst_play", playing, 0);
    check("rst_over", game_over, 0);
    step();
    check("rst_q", bus.lives_q, 0);
    clr_n = 1'b1;
    step();
    check("idle_clr", bus.cnt_clr, 0);

    start = 1'b1;
    step();
    check("load_ld", bus.cnt_ld, 1);
    check("load_d", bus.cnt_d, 3);
    check("load_ent", bus.cnt_ent, 0);
    start = 1'b0;
    step();
    check("settle_q", bus.lives_q, 3);
    check("settle_play", playing, 0);
    step();
    check("play_play", playing, 1);
    check("play_q", bus.lives_q, 3);

    collision = 1'b1;
    step();
    check("hit_ent", bus.cnt_ent, 1);
    check("hit_enp", bus.cnt_enp, 1);
    check("hit_lost", life_lost, 1);
    check("hit_ld", bus.cnt_ld, 0);
    collision = 1'b0;
    step();
    check("chk_q", bus.lives_q, 2);
    check("chk_lost", life_lost, 0);
    check("chk_ent", bus.cnt_ent, 0);
    step();
    check("inv_on", invulnerable, 1);

    frame_tick = 1'b1;
    n = 0;
    saw_dec = 1'b0;
    while (invulnerable && n < 200) begin
      collision = (n == 10);
      step();
      n++;
      if (bus.cnt_ent) saw_dec = 1'b1;
    end
    collision = 1'b0;
    frame_tick = 1'b0;
    check("inv_ticks", n[15:0], 60);
    check("inv_coll_ignored", saw_dec, 0);
    check("inv_back_play", playing, 1);
    check("inv_off", invulnerable, 0);
    check("inv_q", bus.lives_q, 2);

    collision = 1'b1; bonus = 1'b1;
    step();
    check("both_ent", bus.cnt_ent, 1);
    check("both_ld", bus.cnt_ld, 0);
    collision = 1'b0; bonus = 1'b0;
    step();
    check("both_q", bus.lives_q, 1);
    check("both_ld2", bus.cnt_ld, 0);
    step();
    run_invuln(n);
    check("inv2_ticks", n[15:0], 60);

    collision = 1'b1;
    step();
    collision = 1'b0;
    step();
    check("last_q", bus.lives_q, 0);
    step();
    check("over", game_over, 1);
    check("over_play", playing, 0);
    check("over_inv", invulnerable, 0);
    collision = 1'b1;
    saw_dec = 1'b0;
    repeat (4) begin
      step();
      if (bus.cnt_ent) saw_dec = 1'b1;
    end
    collision = 1'b0;
    check("over_nodec", saw_dec, 0);
    check("over_q", bus.lives_q, 0);
    check("over_hold", game_over, 1);

    start = 1'b1;
    step();
    check("restart_ld", bus.cnt_ld, 1);
    check("restart_d", bus.cnt_d, 3);
    start = 1'b0;
    step();
    step();
    check("restart_q", bus.lives_q, 3);
    check("restart_play", playing, 1);
    check("restart_over", game_over, 0);

    for (int i = 4; i <= 9; i++) begin
      bonus = 1'b1;
      step();
      check("bonus_ld", bus.cnt_ld, 1);
      check("bonus_d", bus.cnt_d, 16'(i));
      bonus = 1'b0;
      step();
      step();
      check("bonus_q", bus.lives_q, 16'(i));
      check("bonus_play", playing, 1);
    end
    bonus = 1'b1;
    step();
    check("max_no_ld", bus.cnt_ld, 0);
    bonus = 1'b0;
    step();
    check("max_q", bus.lives_q, 9);

    collision = 1'b1;
    step();
    collision = 1'b0;
    step();
    check("hit9_q", bus.lives_q, 8);
    step();
    check("hit9_inv", invulnerable, 1);
    frame_tick = 1'b1;
    repeat (20) step();
    frame_tick = 1'b0;
    check("part_inv", invulnerable, 1);
    bonus = 1'b1;
    step();
    check("inv_bonus_ld", bus.cnt_ld, 1);
    check("inv_bonus_d", bus.cnt_d, 9);
    bonus = 1'b0;
    step();
    step();
    check("inv_bonus_ret", invulnerable, 1);
    check("inv_bonus_q", bus.lives_q, 9);
    run_invuln(n);
    check("inv_preserved", n[15:0], 40);

    collision = 1'b1;
    step();
    collision = 1'b0;
    step();
    step();
    check("pre_rst_inv", invulnerable, 1);
    check("pre_rst_q", bus.lives_q, 8);
    frame_tick = 1'b1;
    repeat (30) step();
    frame_tick = 1'b0;
    check("mid_inv", invulnerable, 1);
    clr_n = 1'b0;
    step();
    check("mrst_clr", bus.cnt_clr, 1);
    check("mrst_inv", invulnerable, 0);
    check("mrst_play", playing, 0);
    check("mrst_ld", bus.cnt_ld, 0);
    clr_n = 1'b1;
    step();
    check("mrst_q", bus.lives_q, 0);
    check("mrst_clr_off", bus.cnt_clr, 0);
    check("mrst_inv2", invulnerable, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
